// File: rtl/id_pkg.sv
// Shared constants and state encoding for the identifier
// generator and recognizer.
package id_pkg;

  localparam logic [7:0] CH_A   = 8'h41;
  localparam logic [7:0] CH_Z   = 8'h5A;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_NUL = 8'h00;

  localparam int DEF_DIGITS      = 4;
  localparam int DEF_NUM_W       = 14;
  localparam int DEF_MAX_LETTERS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_LETTERS,
    S_DIGITS,
    S_TERM
  } state_t;

  function automatic logic [7:0] next_letter(
    input logic [7:0] c
  );
    return (c == CH_Z) ? CH_A : c + 8'd1;
  endfunction

endpackage

// File: rtl/id_bcd_conv.sv
// Sequential double-dabble: one shift-add-3 step per cycle,
// ready NUM_W cycles after load.
module id_bcd_conv
  import id_pkg::*;
#(
  parameter int NUM_W  = DEF_NUM_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [NUM_W-1:0]    bin,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ready
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] sh_q, sh_d;
  logic [BW-1:0]    bcd_q, bcd_d, adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             rdy_q, rdy_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    rdy_d = rdy_q;
    if (load) begin
      sh_d  = bin;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
      rdy_d = 1'b0;
    end else if (run_q) begin
      bcd_d = {adj[BW-2:0], sh_q[NUM_W-1]};
      sh_d  = {sh_q[NUM_W-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(NUM_W - 1)) begin
        run_d = 1'b0;
        rdy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      rdy_q <= rdy_d;
    end
  end

  assign bcd   = bcd_q;
  assign ready = rdy_q;

endmodule

// File: rtl/id_gen.sv
// Identifier character-stream generator: letters, zero-padded
// decimal number, NUL terminator, one character per clock.
module id_gen
  import id_pkg::*;
#(
  parameter int MAX_LETTERS = DEF_MAX_LETTERS,
  parameter int NUM_W       = DEF_NUM_W,
  parameter int DIGITS      = DEF_DIGITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       letter_base,
  input  logic [3:0]       letter_cnt,
  input  logic [NUM_W-1:0] number,
  output logic [7:0]       char,
  output logic             char_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW      = 4 * DIGITS;
  localparam int DW      = $clog2(DIGITS + 1);
  localparam int MAX_NUM = 10 ** DIGITS - 1;

  state_t          state_q, state_d;
  logic [7:0]      let_q, let_d;
  logic [3:0]      left_q, left_d;
  logic [DW-1:0]   dig_q, dig_d;
  logic [7:0]      char_q, char_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic             load;
  logic [NUM_W-1:0] num_sat;
  logic [BW-1:0]    bcd;
  logic             ready;
  logic [7:0]       digit_ch;
  logic             base_ok;

  assign load    = (state_q == S_IDLE) && start;
  assign num_sat = (number > NUM_W'(MAX_NUM))
                 ? NUM_W'(MAX_NUM) : number;
  assign base_ok = (letter_base >= CH_A)
                && (letter_base <= CH_Z);

  id_bcd_conv #(
    .NUM_W  (NUM_W),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .bin   (num_sat),
    .bcd   (bcd),
    .ready (ready)
  );

  // Most-significant nibble first.
  always_comb begin
    digit_ch = CH_0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q == DW'(i))
        digit_ch = CH_0
                 + {4'h0, bcd[4*(DIGITS-1-i) +: 4]};
    end
  end

  always_comb begin
    state_d = state_q;
    let_d   = let_q;
    left_d  = left_q;
    dig_d   = dig_q;
    char_d  = CH_NUL;
    valid_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CONV;
          let_d   = base_ok ? letter_base : CH_A;
          left_d  = (letter_cnt > 4'(MAX_LETTERS))
                  ? 4'(MAX_LETTERS) : letter_cnt;
          dig_d   = '0;
        end
      end
      S_CONV, S_LETTERS: begin
        if (state_q == S_LETTERS || ready) begin
          valid_d = 1'b1;
          if (left_q == 4'd0) begin
            state_d = S_DIGITS;
            char_d  = digit_ch;
            dig_d   = dig_q + 1'b1;
          end else begin
            state_d = S_LETTERS;
            char_d  = let_q;
            let_d   = next_letter(let_q);
            left_d  = left_q - 4'd1;
          end
        end
      end
      S_DIGITS: begin
        valid_d = 1'b1;
        if (dig_q == DW'(DIGITS)) begin
          state_d = S_TERM;
          char_d  = CH_NUL;
          done_d  = 1'b1;
        end else begin
          char_d = digit_ch;
          dig_d  = dig_q + 1'b1;
        end
      end
      S_TERM:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      let_q   <= CH_A;
      left_q  <= '0;
      dig_q   <= '0;
      char_q  <= CH_NUL;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      let_q   <= let_d;
      left_q  <= left_d;
      dig_q   <= dig_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign char       = char_q;
  assign char_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_id_gen.sv
// Scoreboard bench for id_gen: random and directed requests
// against a character-level reference model.
module tb_id_gen;
  import id_pkg::*;

  localparam int NUM_W  = 14;
  localparam int DIGITS = 4;
  localparam int MAXL   = 8;
  localparam int LIM    = 200;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [7:0]       letter_base;
  logic [3:0]       letter_cnt;
  logic [NUM_W-1:0] number;
  logic [7:0]       char;
  logic             char_valid;
  logic             busy;
  logic             done;

  typedef struct {
    logic [7:0] ch;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  id_gen #(
    .MAX_LETTERS (MAXL),
    .NUM_W       (NUM_W),
    .DIGITS      (DIGITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .letter_base (letter_base),
    .letter_cnt  (letter_cnt),
    .number      (number),
    .char        (char),
    .char_valid  (char_valid),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int expv);
    nvec++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endfunction

  // Reference: the character sequence a request must produce.
  function automatic void push_model(int b, int c, int num);
    int l, off, n, dv;
    l   = (c > MAXL) ? MAXL : c;
    off = (b >= 65 && b <= 90) ? b - 65 : 0;
    for (int i = 0; i < l; i++)
      exp_q.push_back('{8'(65 + (off + i) % 26), 1'b0});
    n  = (num > 9999) ? 9999 : num;
    dv = 10 ** (DIGITS - 1);
    for (int d = 0; d < DIGITS; d++) begin
      exp_q.push_back('{8'(48 + (n / dv) % 10), 1'b0});
      dv = dv / 10;
    end
    exp_q.push_back('{8'h00, 1'b1});
  endfunction

  // Monitor: pops one expected character per valid cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (char_valid) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_char: got %0h expected none",
                   char);
        end else begin
          e = exp_q.pop_front();
          chk("char", int'(char), int'(e.ch));
          chk("done", int'(done), int'(e.dn));
        end
      end else begin
        chk("idle_char", int'(char), 0);
        chk("idle_done", int'(done), 0);
      end
    end
  end

  task automatic scramble();
    letter_base = 8'($urandom);
    letter_cnt  = 4'($urandom);
    number      = NUM_W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) chk("timeout_idle", n, 0);
  endtask

  task automatic start_req(input logic [7:0] b,
                           input logic [3:0] c,
                           input int num);
    int n = 0;
    wait_idle();
    letter_base = b;
    letter_cnt  = c;
    number      = NUM_W'(num);
    start       = 1'b1;
    @(posedge clk);
    push_model(int'(b), int'(c), num);
    #1;
    start = 1'b0;
    scramble();
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
    while (!char_valid && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("first_char_latency", n, NUM_W + 1);
  endtask

  task automatic run_req(input logic [7:0] b,
                         input logic [3:0] c,
                         input int num,
                         input int pulse_at,
                         input bit pulse_term);
    int n = 0;
    start_req(b, c, num);
    while (!done && n < LIM) begin
      start = (n == pulse_at);
      if (start) scramble();
      @(negedge clk);
      n++;
    end
    if (n >= LIM) chk("timeout_done", n, 0);
    start = pulse_term;
    if (pulse_term) scramble();
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_term", int'(busy), 0);
    @(negedge clk);
    chk("busy_stays_low", int'(busy), 0);
  endtask

  task automatic held_start();
    int n = 0;
    wait_idle();
    letter_base = 8'h4B;
    letter_cnt  = 4'd3;
    number      = NUM_W'(4021);
    start       = 1'b1;
    @(posedge clk);
    push_model(8'h4B, 3, 4021);
    while (!done && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) chk("timeout_held", n, 0);
    @(negedge clk);
    chk("held_idle_gap", int'(busy), 0);
    @(posedge clk);
    push_model(8'h4B, 3, 4021);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("held_restart", int'(busy), 1);
    n = 0;
    while (!done && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) chk("timeout_held2", n, 0);
    @(negedge clk);
    chk("held_end", int'(busy), 0);
  endtask

  task automatic reset_mid();
    start_req(8'h43, 4'd2, 55);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_char", int'(char), 0);
    chk("rst_valid", int'(char_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    letter_base = 8'h41;
    letter_cnt  = 4'd0;
    number      = '0;
    #12;
    chk("reset_char", int'(char), 0);
    chk("reset_valid", int'(char_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_req(8'h41, 4'd4, 123, -1, 1'b0);
    run_req(8'h59, 4'd3, 7, 4, 1'b1);
    run_req(8'h7A, 4'd0, 9999, 2, 1'b0);
    run_req(8'h41, 4'd12, 16383, -1, 1'b1);
    run_req(8'h5A, 4'd15, 10000, 9, 1'b0);
    held_start();
    reset_mid();
    run_req(8'h41, 4'd4, 123, -1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_req(8'($urandom_range(8'h38, 8'h80)),
              4'($urandom_range(0, 15)),
              int'($urandom_range(0, 16383)),
              int'($urandom_range(0, 12)),
              1'($urandom));
    end

    chk("leftover_expected", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
